// File: rtl/countdown_ctrl.sv
// Run/pause/clear sequencer for a two-digit BCD countdown with expiry detection
// and a blink flag for the seven-segment scan logic while the count sits at 00.
module countdown_ctrl #(
    parameter int INIT_TENS   = 3,
    parameter int INIT_ONES   = 0,
    parameter int BLINK_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic       blank,
    output logic [1:0] dbg_state
);

    // Inputs are single-cycle pulses sampled on every clk edge; there is no
    // valid/ready handshake, a pulse held for N cycles acts as N pulses.

    localparam logic [3:0] PRE_TENS    = 4'(INIT_TENS);
    localparam logic [3:0] PRE_ONES    = 4'(INIT_ONES);
    localparam logic       PRESET_ZERO = (INIT_TENS == 0) && (INIT_ONES == 0);
    localparam int         CW          = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic [CW-1:0] blink_cnt_q;
    logic          blank_q;
    logic          running_q;
    logic          done_q;

    logic [3:0]    tens_d;
    logic [3:0]    ones_d;
    logic          dec_zero;

    // Decremented BCD pair; only consumed in RUN, where the value is never 00.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q - 4'd1;
        if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
        end
        dec_zero = (tens_d == 4'd0) && (ones_d == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tens_q      <= PRE_TENS;
            ones_q      <= PRE_ONES;
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else if (btn_clear) begin
            state_q     <= S_IDLE;
            tens_q      <= PRE_TENS;
            ones_q      <= PRE_ONES;
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_start) begin
                        if (PRESET_ZERO) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            blank_q     <= 1'b0;
                            blink_cnt_q <= '0;
                        end else begin
                            state_q   <= S_RUN;
                            running_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A tick and a start in the same cycle both apply; expiry beats pause.
                    if (tick) begin
                        tens_q <= tens_d;
                        ones_q <= ones_d;
                        if (dec_zero) begin
                            state_q     <= S_DONE;
                            running_q   <= 1'b0;
                            done_q      <= 1'b1;
                            blank_q     <= 1'b0;
                            blink_cnt_q <= '0;
                        end else if (btn_start) begin
                            state_q   <= S_PAUSE;
                            running_q <= 1'b0;
                        end
                    end else if (btn_start) begin
                        state_q   <= S_PAUSE;
                        running_q <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (btn_start) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (tick) begin
                        if (blink_cnt_q == BLINK_LAST) begin
                            blank_q     <= ~blank_q;
                            blink_cnt_q <= '0;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tens      = tens_q;
    assign ones      = ones_q;
    assign running   = running_q;
    assign done      = done_q;
    assign blank     = blank_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: default, BLINK_TICKS=2 and preset-00 instances share
// stimulus; each phase resets and checks one instance against hand-computed values.
module tb_countdown_ctrl;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic btn_start = 1'b0;
    logic btn_clear = 1'b0;

    logic [3:0] tens0, ones0, tens1, ones1, tens2, ones2;
    logic       run0, done0, blank0, run1, done1, blank1, run2, done2, blank2;
    logic [1:0] st0, st1, st2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    countdown_ctrl u_def (
        .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
        .tens(tens0), .ones(ones0), .running(run0), .done(done0), .blank(blank0),
        .dbg_state(st0)
    );

    countdown_ctrl #(.INIT_TENS(3), .INIT_ONES(0), .BLINK_TICKS(2)) u_b2 (
        .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
        .tens(tens1), .ones(ones1), .running(run1), .done(done1), .blank(blank1),
        .dbg_state(st1)
    );

    countdown_ctrl #(.INIT_TENS(0), .INIT_ONES(0), .BLINK_TICKS(1)) u_zero (
        .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
        .tens(tens2), .ones(ones2), .running(run2), .done(done2), .blank(blank2),
        .dbg_state(st2)
    );

    typedef struct {
        string      name;
        logic       start;
        logic       clear;
        logic       tk;
        logic [3:0] e_tens;
        logic [3:0] e_ones;
        logic       e_run;
        logic       e_done;
        logic       e_blank;
        logic [1:0] e_state;
    } vec_t;

    vec_t tbl[16];

    task automatic step(input logic s, input logic c, input logic t);
        @(negedge clk);
        rst       = 1'b0;
        btn_start = s;
        btn_clear = c;
        tick      = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        tick      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string name, input int sel,
                       input logic [3:0] et, input logic [3:0] eo,
                       input logic er, input logic ed, input logic eb,
                       input logic [1:0] es);
        logic [3:0] at, ao;
        logic       ar, ad, ab;
        logic [1:0] as;
        case (sel)
            0:       begin at = tens0; ao = ones0; ar = run0; ad = done0; ab = blank0; as = st0; end
            1:       begin at = tens1; ao = ones1; ar = run1; ad = done1; ab = blank1; as = st1; end
            default: begin at = tens2; ao = ones2; ar = run2; ad = done2; ab = blank2; as = st2; end
        endcase
        n_tests++;
        if (at !== et || ao !== eo || ar !== ar || ar !== er || ad !== ed || ab !== eb || as !== es) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got tens=%0d ones=%0d run=%b done=%b blank=%b st=%0d, want tens=%0d ones=%0d run=%b done=%b blank=%b st=%0d",
                     name, sel, at, ao, ar, ad, ab, as, et, eo, er, ed, eb, es);
        end
    endtask

    task automatic setv(input int i, input string name, input logic s, input logic c,
                        input logic t, input logic [3:0] et, input logic [3:0] eo,
                        input logic er, input logic [1:0] es);
        tbl[i].name    = name;
        tbl[i].start   = s;
        tbl[i].clear   = c;
        tbl[i].tk      = t;
        tbl[i].e_tens  = et;
        tbl[i].e_ones  = eo;
        tbl[i].e_run   = er;
        tbl[i].e_done  = 1'b0;
        tbl[i].e_blank = 1'b0;
        tbl[i].e_state = es;
    endtask

    initial begin
        int v;

        // Pause/resume table on the default instance, starting from DONE.
        setv(0,  "clear_to_idle",    0, 1, 0, 4'd3, 4'd0, 0, ST_IDLE);
        setv(1,  "idle_start_tick",  1, 0, 1, 4'd3, 4'd0, 1, ST_RUN);
        setv(2,  "run_29",           0, 0, 1, 4'd2, 4'd9, 1, ST_RUN);
        setv(3,  "run_28",           0, 0, 1, 4'd2, 4'd8, 1, ST_RUN);
        setv(4,  "run_27",           0, 0, 1, 4'd2, 4'd7, 1, ST_RUN);
        setv(5,  "run_26",           0, 0, 1, 4'd2, 4'd6, 1, ST_RUN);
        setv(6,  "run_25",           0, 0, 1, 4'd2, 4'd5, 1, ST_RUN);
        setv(7,  "pause_at_25",      1, 0, 0, 4'd2, 4'd5, 0, ST_PAUSE);
        setv(8,  "pause_tick1",      0, 0, 1, 4'd2, 4'd5, 0, ST_PAUSE);
        setv(9,  "pause_tick2",      0, 0, 1, 4'd2, 4'd5, 0, ST_PAUSE);
        setv(10, "pause_tick3",      0, 0, 1, 4'd2, 4'd5, 0, ST_PAUSE);
        setv(11, "pause_tick4",      0, 0, 1, 4'd2, 4'd5, 0, ST_PAUSE);
        setv(12, "pause_tick5",      0, 0, 1, 4'd2, 4'd5, 0, ST_PAUSE);
        setv(13, "resume",           1, 0, 0, 4'd2, 4'd5, 1, ST_RUN);
        setv(14, "resume_tick_24",   0, 0, 1, 4'd2, 4'd4, 1, ST_RUN);
        setv(15, "idle_cycle_24",    0, 0, 0, 4'd2, 4'd4, 1, ST_RUN);

        // Default instance: reset, full 30-tick run, blink with BLINK_TICKS=1.
        do_reset();
        chk("reset_def", 0, 4'd3, 4'd0, 0, 0, 0, ST_IDLE);
        chk("reset_zero", 2, 4'd0, 4'd0, 0, 0, 0, ST_IDLE);
        step(1'b1, 1'b0, 1'b0);
        chk("start_30", 0, 4'd3, 4'd0, 1, 0, 0, ST_RUN);
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b0, 1'b1);
            v = 30 - k;
            if (k < 30) chk("count", 0, 4'(v / 10), 4'(v % 10), 1, 0, 0, ST_RUN);
            else        chk("expire", 0, 4'd0, 4'd0, 0, 1, 0, ST_DONE);
        end
        step(1'b0, 1'b0, 1'b1);
        chk("done_blink1_on", 0, 4'd0, 4'd0, 0, 1, 1, ST_DONE);
        step(1'b0, 1'b0, 1'b1);
        chk("done_blink1_off", 0, 4'd0, 4'd0, 0, 1, 0, ST_DONE);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].start, tbl[i].clear, tbl[i].tk);
            chk(tbl[i].name, 0, tbl[i].e_tens, tbl[i].e_ones, tbl[i].e_run,
                tbl[i].e_done, tbl[i].e_blank, tbl[i].e_state);
        end

        // Clear beats start in the same cycle.
        tick_n(7);
        chk("run_17", 0, 4'd1, 4'd7, 1, 0, 0, ST_RUN);
        step(1'b1, 1'b1, 1'b0);
        chk("clear_over_start", 0, 4'd3, 4'd0, 0, 0, 0, ST_IDLE);

        // Ones wrap and expiry coinciding with start.
        step(1'b1, 1'b0, 1'b0);
        tick_n(20);
        chk("run_10", 0, 4'd1, 4'd0, 1, 0, 0, ST_RUN);
        step(1'b0, 1'b0, 1'b1);
        chk("wrap_09", 0, 4'd0, 4'd9, 1, 0, 0, ST_RUN);
        tick_n(8);
        chk("run_01", 0, 4'd0, 4'd1, 1, 0, 0, ST_RUN);
        step(1'b1, 1'b0, 1'b1);
        chk("done_over_pause", 0, 4'd0, 4'd0, 0, 1, 0, ST_DONE);
        step(1'b1, 1'b0, 1'b0);
        chk("done_ignores_start", 0, 4'd0, 4'd0, 0, 1, 0, ST_DONE);

        // Synchronous reset mid-run.
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        tick_n(18);
        chk("run_12", 0, 4'd1, 4'd2, 1, 0, 0, ST_RUN);
        do_reset();
        chk("reset_mid_run", 0, 4'd3, 4'd0, 0, 0, 0, ST_IDLE);

        // BLINK_TICKS=2 instance.
        do_reset();
        chk("b2_reset", 1, 4'd3, 4'd0, 0, 0, 0, ST_IDLE);
        step(1'b1, 1'b0, 1'b0);
        tick_n(30);
        chk("b2_enter_done", 1, 4'd0, 4'd0, 0, 1, 0, ST_DONE);
        step(1'b0, 1'b0, 1'b1);
        chk("b2_t1", 1, 4'd0, 4'd0, 0, 1, 0, ST_DONE);
        step(1'b0, 1'b0, 1'b1);
        chk("b2_t2", 1, 4'd0, 4'd0, 0, 1, 1, ST_DONE);
        step(1'b0, 1'b0, 1'b0);
        chk("b2_no_tick_hold", 1, 4'd0, 4'd0, 0, 1, 1, ST_DONE);
        step(1'b0, 1'b0, 1'b1);
        chk("b2_t3", 1, 4'd0, 4'd0, 0, 1, 1, ST_DONE);
        step(1'b1, 1'b0, 1'b0);
        chk("b2_start_ignored", 1, 4'd0, 4'd0, 0, 1, 1, ST_DONE);
        step(1'b0, 1'b0, 1'b1);
        chk("b2_t4", 1, 4'd0, 4'd0, 0, 1, 0, ST_DONE);
        step(1'b0, 1'b0, 1'b1);
        chk("b2_t5", 1, 4'd0, 4'd0, 0, 1, 0, ST_DONE);
        step(1'b0, 1'b0, 1'b1);
        chk("b2_t6", 1, 4'd0, 4'd0, 0, 1, 1, ST_DONE);
        step(1'b0, 1'b1, 1'b0);
        chk("b2_clear", 1, 4'd3, 4'd0, 0, 0, 0, ST_IDLE);

        // Preset 00 instance.
        do_reset();
        chk("zero_reset", 2, 4'd0, 4'd0, 0, 0, 0, ST_IDLE);
        step(1'b1, 1'b0, 1'b1);
        chk("zero_start_done", 2, 4'd0, 4'd0, 0, 1, 0, ST_DONE);
        step(1'b0, 1'b0, 1'b1);
        chk("zero_no_wrap1", 2, 4'd0, 4'd0, 0, 1, 1, ST_DONE);
        step(1'b0, 1'b0, 1'b1);
        chk("zero_no_wrap2", 2, 4'd0, 4'd0, 0, 1, 0, ST_DONE);
        step(1'b1, 1'b0, 1'b1);
        chk("zero_start_tick", 2, 4'd0, 4'd0, 0, 1, 1, ST_DONE);
        step(1'b0, 1'b1, 1'b0);
        chk("zero_clear", 2, 4'd0, 4'd0, 0, 0, 0, ST_IDLE);

        step(1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
